// File: rtl/timer_arbiter.sv
// timer_arbiter: one shared up-counter time-sliced among NUM_REQ requesters.
// Round-robin grant in IDLE, count 0..len_q in RUN, one-cycle done pulse in DONE.
// Optional: define TIMER_ARB_STATS_EN to add a saturating done_total counter port.
module timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [WIDTH-1:0]         count
`ifdef TIMER_ARB_STATS_EN
  ,
  output logic [15:0]              done_total
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] len_q;
  logic [IW-1:0]    last;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    winner;

  // Round-robin search: first requester with req high after the last one served.
  always_comb begin
    logic        found;
    int unsigned idx;
    found  = 1'b0;
    idx    = 0;
    winner = last;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  // Main controller: arbitration, interval counting, done pulse.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
      count <= '0;
      len_q <= '0;
      last  <= IW'(NUM_REQ - 1);
      owner <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant <= ONE << winner;
            last  <= winner;
            owner <= winner;
            len_q <= req_len[winner*WIDTH +: WIDTH];
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Cancel is tested first so it wins over a coincident terminal count.
          if (!req[owner]) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (count == len_q) begin
            grant <= '0;
            done  <= ONE << owner;
            state <= DONE;
          end else begin
            count <= count + WIDTH'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef TIMER_ARB_STATS_EN
  // Completed-interval counter: bumps on each edge entering DONE, saturating.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      done_total <= '0;
    end else if (state == RUN && req[owner] && count == len_q && done_total != 16'hFFFF) begin
      done_total <= done_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: stimulus pushes predicted transactions,
// a negedge monitor expands them into per-cycle expectations and compares.
module tb_timer_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic             clock;
  logic             resetN;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_len;
  logic [N-1:0]     grant;
  logic [N-1:0]     done;
  logic             busy;
  logic [W-1:0]     count;
`ifdef TIMER_ARB_STATS_EN
  logic [15:0]      done_total;
`endif

  timer_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .req        (req),
    .req_len    (req_len),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .count      (count)
`ifdef TIMER_ARB_STATS_EN
    ,
    .done_total (done_total)
`endif
  );

  typedef struct {
    int w;
    int len;
    int cancel_k;
    int grant_cyc;
  } item_t;

  typedef struct {
    logic [N-1:0] g;
    logic [N-1:0] d;
    logic         b;
    int           c;
  } samp_t;

  item_t items[$];
  samp_t samps[$];
  int    cyc = 0;
  int    passed = 0;
  int    total = 0;
  bit    in_reset = 1'b1;
  int    model_last = N - 1;
  int    completions = 0;

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  function automatic void chk(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference arbitration: first set bit scanning after the last winner.
  function automatic int pick(logic [N-1:0] mask);
    for (int i = 1; i <= N; i++) begin
      int idx;
      idx = (model_last + i) % N;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  // Expand one transaction into the per-cycle picture the block must show.
  function automatic void expand(item_t it);
    samp_t s;
    logic [N-1:0] oh;
    int last_j;
    oh = N'(1) << it.w;
    last_j = (it.cancel_k >= 0) ? it.cancel_k : it.len;
    for (int j = 0; j <= last_j; j++) begin
      s.g = oh; s.d = '0; s.b = 1'b1; s.c = j;
      samps.push_back(s);
    end
    if (it.cancel_k >= 0) begin
      s.g = '0; s.d = '0; s.b = 1'b0; s.c = it.cancel_k;
      samps.push_back(s);
    end else begin
      s.g = '0; s.d = oh; s.b = 1'b1; s.c = it.len;
      samps.push_back(s);
      s.g = '0; s.d = '0; s.b = 1'b0; s.c = it.len;
      samps.push_back(s);
    end
  endfunction

  // Monitor: outputs are registered, so sampling on the falling edge is stable.
  always @(negedge clock) begin
    samp_t s;
    item_t it;
    if (in_reset) begin
      samps.delete();
      items.delete();
      chk("rst_grant", grant, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", count, 0);
    end else if (samps.size() > 0 || grant != '0) begin
      if (samps.size() == 0) begin
        if (items.size() == 0) begin
          chk("unexpected_grant", grant, 0);
        end else begin
          it = items.pop_front();
          chk("grant_latency", cyc, it.grant_cyc);
          expand(it);
        end
      end
      if (samps.size() > 0) begin
        s = samps.pop_front();
        chk("grant", grant, s.g);
        chk("done", done, s.d);
        chk("busy", busy, s.b);
        chk("count", count, s.c);
      end
    end else begin
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      if (items.size() > 0 && cyc > items[0].grant_cyc) begin
        chk("grant_timeout", cyc, items[0].grant_cyc);
        void'(items.pop_front());
      end
    end
  end

  function automatic logic [N*W-1:0] rand_lens(int maxv);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom_range(0, maxv));
    return v;
  endfunction

  function automatic logic [N*W-1:0] all_lens(int val);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(val);
    return v;
  endfunction

  // Caller is positioned at a falling edge with the block idle at the next edge;
  // returns at a falling edge with the block idle again.
  task automatic run_txn(input logic [N-1:0] mask, input logic [N*W-1:0] lens,
                         input int cancel_k, input bit drop);
    item_t it;
    int w;
    w = pick(mask);
    req = mask;
    req_len = lens;
    it.w = w;
    it.len = int'(lens[w*W +: W]);
    it.cancel_k = cancel_k;
    it.grant_cyc = cyc + 1;
    items.push_back(it);
    model_last = w;
    @(negedge clock);
    req_len = {$urandom(), $urandom()};
    if (cancel_k >= 0) begin
      repeat (cancel_k) @(negedge clock);
      req[w] = 1'b0;
      @(negedge clock);
    end else begin
      repeat (it.len + 1) @(negedge clock);
      if (drop) req = '0;
      @(negedge clock);
      completions++;
    end
  endtask

  task automatic gap(input int n);
    req = '0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

  initial begin
    logic [N-1:0]   mask;
    logic [N*W-1:0] lens;
    int w, len, ck;

    req = '0;
    req_len = '0;
    resetN = 1'b0;
    #2;
    chk("por_grant", grant, 0);
    chk("por_busy", busy, 0);
    #1;
    chk("por_done", done, 0);
    chk("por_count", count, 0);
    #2 resetN = 1'b1;
    #1 in_reset = 1'b0;
    @(negedge clock);
    chk("post_rst_count", count, 0);
    chk("post_rst_grant", grant, 0);

    // Round-robin with all requests held: order 0,1,2,3,0.
    for (int i = 0; i < 5; i++) run_txn(4'b1111, all_lens(2), -1, i == 4);
    gap(2);

    // Single request of length 5.
    lens = rand_lens(9);
    lens[0 +: W] = 16'd5;
    run_txn(4'b0001, lens, -1, 1'b1);
    gap(1);

    // Cancel requester 2 at count 4; next search starts at 3.
    lens = rand_lens(9);
    lens[2*W +: W] = 16'd10;
    run_txn(4'b0100, lens, 4, 1'b1);
    run_txn(4'b1111, rand_lens(6), -1, 1'b1);
    gap(1);

    // Zero-length interval.
    run_txn(4'b0001, all_lens(0), -1, 1'b1);
    gap(1);

    // Cancel on the same edge as terminal count.
    run_txn(4'b0010, all_lens(3), 3, 1'b1);
    gap(1);

    // Maximum length: no wrap before done.
    run_txn(4'b1000, all_lens(16'hFFFF), -1, 1'b1);
    gap(2);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      lens = rand_lens(12);
      w = pick(mask);
      len = int'(lens[w*W +: W]);
      ck = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      run_txn(mask, lens, ck, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) gap(int'($urandom_range(0, 2)));
    end
    gap(2);

    // Asynchronous reset in the middle of a long interval.
    req = 4'b0010;
    req_len = all_lens(300);
    begin
      item_t it;
      it.w = pick(4'b0010);
      it.len = 300;
      it.cancel_k = -1;
      it.grant_cyc = cyc + 1;
      items.push_back(it);
      model_last = it.w;
    end
    repeat (101) @(negedge clock);
    chk("pre_reset_count", count, 100);
    #2 resetN = 1'b0;
    in_reset = 1'b1;
    completions = 0;
    #1;
    chk("async_rst_grant", grant, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_done", done, 0);
    req = '0;
    repeat (2) @(negedge clock);
    #2 resetN = 1'b1;
    model_last = N - 1;
    #1 in_reset = 1'b0;
    @(negedge clock);
    chk("post_async_count", count, 0);

    // Pointer is back at reset: requester 0 wins first.
    run_txn(4'b1111, rand_lens(4), -1, 1'b1);
    run_txn(4'b1111, rand_lens(4), -1, 1'b1);
    gap(3);

    chk("scoreboard_drained", items.size() + samps.size(), 0);
`ifdef TIMER_ARB_STATS_EN
    chk("done_total", done_total, (completions > 65535) ? 65535 : completions);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
